gpr_file_mp: RTL and testbench

//   Parametrised general-purpose register file: NREG x XLEN storage, NRP read ports, one write port.

---
 rtl/gpr_pkg.sv | 7 +
 rtl/gpr_read_port.sv | 25 ++
 rtl/gpr_file_mp.sv | 63 ++++++
 tb/tb_gpr_file_mp.sv | 127 ++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants and FSM encoding for the general-purpose register file
package gpr_pkg;
  localparam int GPR_XLEN = 32;
  localparam logic GPR_WSEL_DI = 1'b0;
  localparam logic GPR_WSEL_CSR = 1'b1;
  typedef enum logic {GPR_CLEAR = 1'b0, GPR_READY = 1'b1} gpr_state_e;
endpackage

// File: rtl/gpr_read_port.sv
// gpr_read_port: one read port with x0 forcing, write-first bypass and optional output register
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int XLEN = GPR_XLEN,
  parameter int AW = 5,
  parameter int READ_REG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_ra,
  input  logic [XLEN-1:0] i_mem_q,
  input  logic            i_we,
  input  logic [AW-1:0]   i_rd,
  input  logic [XLEN-1:0] i_wdat,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_q
);
  logic [XLEN-1:0] w_val;
  logic [XLEN-1:0] r_q;
  assign w_val = (!i_ready || i_ra == '0) ? '0 : (i_we && i_rd == i_ra) ? i_wdat : i_mem_q;
  always_ff @(posedge clk)
    r_q <= !rst_n ? '0 : w_val;
  assign o_q = (READ_REG != 0) ? r_q : w_val;
endmodule

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: NREG x XLEN register file, NRP read ports, one write port
// a clear sequencer zeroes every entry after reset before the file reports ready
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int XLEN = GPR_XLEN,
  parameter int NREG = 32,
  parameter int NRP = 2,
  parameter int READ_REG = 0,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gpr_we,
  input  logic                gpr_wsel,
  input  logic [AW-1:0]       gpr_rd,
  input  logic [XLEN-1:0]     gpr_di,
  input  logic [XLEN-1:0]     csr_rdata,
  input  logic [NRP*AW-1:0]   gpr_ra,
  output logic [NRP*XLEN-1:0] gpr_q,
  output logic                gpr_ready
);
  gpr_state_e      r_state;
  logic [AW-1:0]   r_clr_cnt;
  logic            r_ready;
  logic [XLEN-1:0] r_mem [NREG];
  logic [XLEN-1:0] w_wdat;
  assign w_wdat = (gpr_wsel == GPR_WSEL_CSR) ? csr_rdata : gpr_di;
  assign gpr_ready = r_ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= GPR_CLEAR;
      r_clr_cnt <= '0;
      r_ready <= 1'b0;
    end else if (r_state == GPR_CLEAR) begin
      if (r_clr_cnt == AW'(NREG - 1)) begin
        r_state <= GPR_READY;
        r_ready <= 1'b1;
      end else
        r_clr_cnt <= r_clr_cnt + AW'(1);
    end
  // writes arriving while clearing are dropped, not queued
  always_ff @(posedge clk)
    if (rst_n) begin
      if (r_state == GPR_CLEAR)
        r_mem[r_clr_cnt] <= '0;
      else if (gpr_we && gpr_rd != '0)
        r_mem[gpr_rd] <= w_wdat;
    end
  for (genvar p = 0; p < NRP; p++) begin : g_rp
    gpr_read_port #(.XLEN(XLEN), .AW(AW), .READ_REG(READ_REG)) u_rp (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ra    (gpr_ra[p*AW +: AW]),
      .i_mem_q (r_mem[gpr_ra[p*AW +: AW]]),
      .i_we    (gpr_we),
      .i_rd    (gpr_rd),
      .i_wdat  (w_wdat),
      .i_ready (r_ready),
      .o_q     (gpr_q[p*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: directed checks of a 32x32/2-port combinational file and a 16x64/3-port registered file
module tb_gpr_file_mp;
  logic         clk = 1'b0;
  logic         rst_n, we, wsel;
  logic [4:0]   rd;
  logic [63:0]  di, csr;
  logic [9:0]   ra_a;
  logic [11:0]  ra_b;
  logic [63:0]  q_a;
  logic [191:0] q_b;
  logic         rdy_a, rdy_b;
  int           n_cmp = 0;
  int           n_err = 0;
  always #5 clk = ~clk;
  gpr_file_mp #(.XLEN(32), .NREG(32), .NRP(2), .READ_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .gpr_we(we), .gpr_wsel(wsel), .gpr_rd(rd),
    .gpr_di(di[31:0]), .csr_rdata(csr[31:0]), .gpr_ra(ra_a), .gpr_q(q_a), .gpr_ready(rdy_a));
  gpr_file_mp #(.XLEN(64), .NREG(16), .NRP(3), .READ_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n), .gpr_we(we), .gpr_wsel(wsel), .gpr_rd(rd[3:0]),
    .gpr_di(di), .csr_rdata(csr), .gpr_ra(ra_b), .gpr_q(q_b), .gpr_ready(rdy_b));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    ra_a = {a1, a0};
    ra_b = {a2[3:0], a1[3:0], a0[3:0]};
  endtask
  task automatic chk_a(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    chk({tag, "_a0"}, {32'h0, q_a[31:0]}, {32'h0, e0});
    chk({tag, "_a1"}, {32'h0, q_a[63:32]}, {32'h0, e1});
  endtask
  task automatic chk_b(input string tag, input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
    chk({tag, "_b0"}, q_b[63:0], e0);
    chk({tag, "_b1"}, q_b[127:64], e1);
    chk({tag, "_b2"}, q_b[191:128], e2);
  endtask
  task automatic clr_seq(input string tag);
    for (int k = 1; k <= 32; k++) begin
      if (k == 3) begin
        we = 1'b1; wsel = 1'b0; rd = 5'd5; di = 64'hDEAD_BEEF_DEAD_BEEF;
        set_ra(5, 5, 5);
        #1 chk_a({tag, "_clrbyp"}, 32'h0, 32'h0);
      end
      if (k == 4) we = 1'b0;
      tick();
      if (k == 3) chk_b({tag, "_clrbyp"}, 64'h0, 64'h0, 64'h0);
      if (k == 15 || k == 16) chk({tag, "_rdy_b"}, {63'h0, rdy_b}, {63'h0, k == 16});
      if (k == 31 || k == 32) chk({tag, "_rdy_a"}, {63'h0, rdy_a}, {63'h0, k == 32});
    end
  endtask
  initial begin
    rst_n = 1'b0; we = 1'b0; wsel = 1'b0; rd = '0; di = '0; csr = '0;
    set_ra(0, 0, 0);
    tick();
    chk("rst_rdy_a", {63'h0, rdy_a}, 64'h0);
    chk("rst_rdy_b", {63'h0, rdy_b}, 64'h0);
    chk_b("rst_q", 64'h0, 64'h0, 64'h0);
    tick();
    rst_n = 1'b1;
    clr_seq("clr1");
    set_ra(5, 5, 5);
    #1 chk_a("drop5", 32'h0, 32'h0);
    tick();
    chk_b("drop5", 64'h0, 64'h0, 64'h0);
    for (int r = 0; r < 32; r++) begin
      set_ra(5'(r), 5'(r), 5'(r));
      #1 chk_a($sformatf("zero%0d", r), 32'h0, 32'h0);
      tick();
      chk_b($sformatf("zero%0d", r), 64'h0, 64'h0, 64'h0);
    end
    we = 1'b1; wsel = 1'b0; rd = 5'd7; di = 64'h0BAD_F00D_1234_5678; csr = 64'h5A5A_5A5A_5A5A_5A5A;
    tick();
    wsel = 1'b1; rd = 5'd8; di = 64'h7777_7777_7777_7777; csr = 64'h1357_9BDF_CAFE_0001;
    tick();
    we = 1'b0;
    set_ra(7, 8, 7);
    #1 chk_a("rd78", 32'h1234_5678, 32'hCAFE_0001);
    tick();
    chk_b("rd78", 64'h0BAD_F00D_1234_5678, 64'h1357_9BDF_CAFE_0001, 64'h0BAD_F00D_1234_5678);
    we = 1'b1; wsel = 1'b0; rd = 5'd0; di = '1;
    set_ra(0, 0, 0);
    #1 chk_a("x0byp", 32'h0, 32'h0);
    tick();
    chk_b("x0byp", 64'h0, 64'h0, 64'h0);
    we = 1'b0;
    #1 chk_a("x0", 32'h0, 32'h0);
    tick();
    chk_b("x0", 64'h0, 64'h0, 64'h0);
    we = 1'b1; rd = 5'd9; di = 64'hA5A5_A5A5_A5A5_A5A5;
    set_ra(9, 9, 9);
    #1 chk_a("byp9", 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    tick();
    chk_b("byp9", 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5);
    we = 1'b0; di = '0;
    set_ra(9, 7, 8);
    #1 chk_a("mix", 32'hA5A5_A5A5, 32'h1234_5678);
    tick();
    chk_b("mix", 64'hA5A5_A5A5_A5A5_A5A5, 64'h0BAD_F00D_1234_5678, 64'h1357_9BDF_CAFE_0001);
    we = 1'b1; rd = 5'd3; di = 64'h0000_0000_0000_00FF;
    set_ra(3, 3, 3);
    tick();
    we = 1'b0;
    #1 chk_a("x3", 32'hFF, 32'hFF);
    tick();
    chk_b("x3", 64'hFF, 64'hFF, 64'hFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rdy_a", {63'h0, rdy_a}, 64'h0);
    chk("mid_rdy_b", {63'h0, rdy_b}, 64'h0);
    clr_seq("clr2");
    set_ra(3, 7, 9);
    #1 chk_a("post", 32'h0, 32'h0);
    tick();
    chk_b("post", 64'h0, 64'h0, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
